// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register controller.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    RD,
    WR,
    ERR
  } state_e;

  localparam int          CMD_RD_BIT = 7;
  localparam int          ADDR_W     = 7;
  localparam logic [7:0]  ERR_BYTE   = 8'hFF;

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Byte-level link between the SPI slave shifter (master side) and the register controller.
interface spi_reg_ctrl_if;

  logic       frame_start;
  logic       frame_end;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [7:0] tx_data;
  logic       tx_load;

  modport master (
    output frame_start, frame_end, rx_valid, rx_data,
    input  tx_data, tx_load
  );

  modport slave (
    input  frame_start, frame_end, rx_valid, rx_data,
    output tx_data, tx_load
  );

endinterface

// File: rtl/spi_reg_bank.sv
// Bank of 8-bit config registers: one synchronous write port, one async read port, flat output.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int         NUM_REGS  = 16,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we_i,
  input  logic [ADDR_W-1:0]       waddr_i,
  input  logic [7:0]              wdata_i,
  input  logic [ADDR_W-1:0]       raddr_i,
  output logic [7:0]              rdata_o,
  output logic [8*NUM_REGS-1:0]   reg_o
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [7:0] regs_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else if (we_i) begin
      regs_q[waddr_i[IDX_W-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = regs_q[raddr_i[IDX_W-1:0]];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_o[8*g +: 8] = regs_q[g];
  end

endmodule

// File: rtl/spi_reg_ctrl.sv
// Frame decoder sequencing SPI reads/writes into a local register bank.
// Optional feature: define SPI_REG_AUTOINC_EN to advance the address after each data byte.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int         NUM_REGS  = 16,
  parameter logic [7:0] RESET_VAL = 8'h00,
  parameter logic [7:0] STATUS    = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst,
  spi_reg_ctrl_if.slave          bus,
  output logic [8*NUM_REGS-1:0]  reg_q,
  output logic                   wr_strobe,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [7:0]             err_cnt
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_load_q, tx_load_d;
  logic               wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [7:0]         err_q, err_d;

  logic               want_load;
  logic [7:0]         load_byte;
  logic               bank_we;
  logic [ADDR_W-1:0]  rd_addr;
  logic [7:0]         rd_data;
  logic [ADDR_W-1:0]  next_addr;
  logic               cmd_in_range;

`ifdef SPI_REG_AUTOINC_EN
  assign next_addr = (addr_q == ADDR_W'(NUM_REGS - 1)) ? '0 : addr_q + 1'b1;
`else
  assign next_addr = addr_q;
`endif

  assign cmd_in_range = int'(bus.rx_data[ADDR_W-1:0]) < NUM_REGS;

  spi_reg_bank #(
    .NUM_REGS  (NUM_REGS),
    .RESET_VAL (RESET_VAL)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .we_i    (bank_we),
    .waddr_i (addr_q),
    .wdata_i (bus.rx_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data),
    .reg_o   (reg_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      tx_data_q   <= STATUS;
      tx_load_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      tx_data_q   <= tx_data_d;
      tx_load_q   <= tx_load_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      err_q       <= err_d;
    end
  end

  // frame_start resyncs from any state; frame_end is applied after the byte in hand is processed
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    tx_data_d   = tx_data_q;
    tx_load_d   = 1'b0;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    err_d       = err_q;
    want_load   = 1'b0;
    load_byte   = tx_data_q;
    bank_we     = 1'b0;
    rd_addr     = addr_q;

    if (bus.frame_start) begin
      state_d   = CMD;
      want_load = 1'b1;
      load_byte = STATUS;
    end else begin
      unique case (state_q)
        CMD: begin
          if (bus.rx_valid) begin
            addr_d = bus.rx_data[ADDR_W-1:0];
            if (!cmd_in_range) begin
              state_d   = ERR;
              want_load = 1'b1;
              load_byte = ERR_BYTE;
              if (err_q != 8'hFF) err_d = err_q + 8'd1;
            end else if (bus.rx_data[CMD_RD_BIT]) begin
              state_d   = RD;
              rd_addr   = bus.rx_data[ADDR_W-1:0];
              want_load = 1'b1;
              load_byte = rd_data;
            end else begin
              state_d = WR;
            end
          end
        end
        RD: begin
          if (bus.rx_valid) begin
            addr_d    = next_addr;
            rd_addr   = next_addr;
            want_load = 1'b1;
            load_byte = rd_data;
          end
        end
        WR: begin
          if (bus.rx_valid) begin
            bank_we     = 1'b1;
            wr_strobe_d = 1'b1;
            wr_addr_d   = addr_q;
            addr_d      = next_addr;
            want_load   = 1'b1;
            load_byte   = bus.rx_data;
          end
        end
        ERR: begin
          if (bus.rx_valid) begin
            want_load = 1'b1;
            load_byte = ERR_BYTE;
          end
        end
        default: ;
      endcase
      if (bus.frame_end) state_d = IDLE;
    end

    if (want_load && !tx_load_q) begin
      tx_load_d = 1'b1;
      tx_data_d = load_byte;
    end
  end

  assign bus.tx_data = tx_data_q;
  assign bus.tx_load = tx_load_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign err_cnt     = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed self-checking bench for spi_reg_ctrl; expectations follow SPI_REG_AUTOINC_EN when defined.
module tb_spi_reg_ctrl;
  import spi_reg_pkg::*;

  localparam int NUM_REGS = 16;

  logic                  clk;
  logic                  rst;
  logic [8*NUM_REGS-1:0] reg_q;
  logic                  wr_strobe;
  logic [ADDR_W-1:0]     wr_addr;
  logic [7:0]            err_cnt;

  spi_reg_ctrl_if bus ();

  spi_reg_ctrl #(
    .NUM_REGS  (NUM_REGS),
    .RESET_VAL (8'h00),
    .STATUS    (8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .reg_q     (reg_q),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checkCount = 0;
  int         passCount  = 0;
  logic [7:0] txq [$];
  int         wrCount    = 0;
  int         lastWrAddr = -1;
  logic [7:0] lastWrData = 8'h00;
  int         backToBack = 0;
  logic       prevLoad   = 1'b0;

  // Record every tx_load byte and register write as seen between clock edges
  always @(negedge clk) begin
    if (bus.tx_load) txq.push_back(bus.tx_data);
    if (bus.tx_load && prevLoad) backToBack++;
    prevLoad = bus.tx_load;
    if (wr_strobe) begin
      wrCount++;
      lastWrAddr = int'(wr_addr);
      lastWrData = reg_q[8*wr_addr +: 8];
    end
  end

  function automatic logic [31:0] regAt(input int n);
    return {24'h0, reg_q[8*n +: 8]};
  endfunction

  function automatic logic [31:0] txAt(input int i);
    return (i < txq.size()) ? {24'h0, txq[i]} : 32'hDEAD_BEEF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic fs, input logic fe, input logic rv, input logic [7:0] d);
    @(posedge clk); #1;
    bus.frame_start = fs;
    bus.frame_end   = fe;
    bus.rx_valid    = rv;
    bus.rx_data     = d;
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
    bus.frame_end   = 1'b0;
    bus.rx_valid    = 1'b0;
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic writeReg(input logic [6:0] addr, input logic [7:0] val);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, {1'b0, addr});
    applyStimulus(1'b0, 1'b0, 1'b1, val);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic clearLogs();
    txq.delete();
    wrCount    = 0;
    lastWrAddr = -1;
  endtask

  initial begin
    bus.frame_start = 1'b0;
    bus.frame_end   = 1'b0;
    bus.rx_valid    = 1'b0;
    bus.rx_data     = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #2;
    $display("[TB] reset state");
    checkOutput("rst_tx_data", {24'h0, bus.tx_data}, 32'hA5);
    checkOutput("rst_tx_load", {31'h0, bus.tx_load}, 32'h0);
    checkOutput("rst_wr_strobe", {31'h0, wr_strobe}, 32'h0);
    checkOutput("rst_wr_addr", {25'h0, wr_addr}, 32'h0);
    checkOutput("rst_err_cnt", {24'h0, err_cnt}, 32'h0);
    checkOutput("rst_regs_nonzero", {31'h0, (reg_q != '0)}, 32'h0);
    checkOutput("rst_state", 32'(dut.state_q), 32'(IDLE));

    $display("[TB] single write");
    clearLogs();
    writeReg(7'h03, 8'h5A);
    checkOutput("t1_status_first", txAt(0), 32'hA5);
    checkOutput("t1_echo", txAt(1), 32'h5A);
    checkOutput("t1_reg3", regAt(3), 32'h5A);
    checkOutput("t1_wr_count", wrCount, 32'd1);
    checkOutput("t1_wr_addr", lastWrAddr, 32'd3);
    checkOutput("t1_wr_data_at_strobe", {24'h0, lastWrData}, 32'h5A);

    $display("[TB] read burst across wrap");
    writeReg(7'h0E, 8'h11);
    writeReg(7'h0F, 8'h22);
    writeReg(7'h00, 8'h33);
    clearLogs();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h8E);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("t2_status", txAt(0), 32'hA5);
    checkOutput("t2_rd0", txAt(1), 32'h11);
`ifdef SPI_REG_AUTOINC_EN
    checkOutput("t2_rd1", txAt(2), 32'h22);
    checkOutput("t2_rd2", txAt(3), 32'h33);
`else
    checkOutput("t2_rd1", txAt(2), 32'h11);
    checkOutput("t2_rd2", txAt(3), 32'h11);
`endif
    checkOutput("t2_no_writes", wrCount, 32'd0);

    $display("[TB] write burst");
    clearLogs();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h02);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h01);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h02);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("t3_wr_count", wrCount, 32'd2);
`ifdef SPI_REG_AUTOINC_EN
    checkOutput("t3_reg2", regAt(2), 32'h01);
    checkOutput("t3_reg3", regAt(3), 32'h02);
    checkOutput("t3_last_addr", lastWrAddr, 32'd3);
`else
    checkOutput("t3_reg2", regAt(2), 32'h02);
    checkOutput("t3_reg3", regAt(3), 32'h5A);
    checkOutput("t3_last_addr", lastWrAddr, 32'd2);
`endif

    $display("[TB] bad address");
    clearLogs();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h40);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h77);
    checkOutput("t4_state_err", 32'(dut.state_q), 32'(ERR));
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("t4_err_cnt", {24'h0, err_cnt}, 32'd1);
    checkOutput("t4_no_wr", wrCount, 32'd0);
    checkOutput("t4_tx_ff", txAt(2), 32'hFF);
    checkOutput("t4_tx_data", {24'h0, bus.tx_data}, 32'hFF);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      applyStimulus(1'b0, 1'b1, 1'b1, 8'h7F);
    end
    checkOutput("t4_err_sat", {24'h0, err_cnt}, 32'd255);
    checkOutput("t4_regs_untouched", regAt(0), 32'h33);

    $display("[TB] byte coincident with frame_end");
    clearLogs();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h05);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hC3);
    checkOutput("t5_reg5", regAt(5), 32'hC3);
    checkOutput("t5_wr_count", wrCount, 32'd1);
    checkOutput("t5_state_idle", 32'(dut.state_q), 32'(IDLE));

    $display("[TB] reset mid burst");
    clearLogs();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h06);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h99);
    checkOutput("t6_reg6_before", regAt(6), 32'h99);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h44;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rx_valid = 1'b0;
    #2;
    checkOutput("t6_regs_cleared", {31'h0, (reg_q != '0)}, 32'h0);
    checkOutput("t6_state_idle", 32'(dut.state_q), 32'(IDLE));
    checkOutput("t6_err_cleared", {24'h0, err_cnt}, 32'h0);
    clearLogs();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("t6_status_reload", txAt(0), 32'hA5);
    checkOutput("t6_one_load", txq.size(), 32'd1);
    checkOutput("t6_state_cmd", 32'(dut.state_q), 32'(CMD));
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);

    checkOutput("no_back_to_back_load", backToBack, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
